// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and defaults
// for the byte-serial data memory sequencer.
package dmem_pkg;

    localparam int MEM_BYTES_DEF = 1024;

    localparam logic [1:0] SZ_WORD = 2'b11;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_NONE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_DONE,
        ST_HALT
    } state_t;

    // Index of the final beat (N-1) for a given size.
    function automatic logic [1:0] last_beat(input logic [1:0] num);
        logic [1:0] r;
        unique case (num)
            SZ_WORD: r = 2'd3;
            SZ_HALF: r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_range_check.sv
// dmem_range_check: combinational range/alignment check.
// Ports: addr, num in; overflow, misalign out.
module dmem_range_check
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic [31:0] addr,
    input  logic [1:0]  num,
    output logic        overflow,
    output logic        misalign
);

    logic [32:0] last;

    // 33-bit sum so an access near 2^32 cannot wrap to a small address.
    always_comb begin
        last     = {1'b0, addr} + {31'b0, last_beat(num)};
        overflow = (num != SZ_NONE)
                && (last >= 33'(MEM_BYTES));
        misalign = ((num == SZ_WORD) && (addr[1:0] != 2'b00))
                || ((num == SZ_HALF) && addr[0]);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: splits CPU word/half/byte accesses into big-endian
// byte beats. Ports: CPU req/we/num/addr/wdata -> rdata/done/errors/halt; byte memory strobes.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        num_i,
    input  logic              unsigned_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              error_addressOverflow_o,
    output logic              error_dataMisalign_o,
    output logic              halt_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    state_t state_q, state_d;

    logic              we_q;
    logic              uns_q;
    logic [1:0]        num_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;
    logic [31:0]       acc_q;
    logic [1:0]        beat_q;
    logic              ovf_q;
    logic              mis_q;

    logic        ovf;
    logic        mis;
    logic        accept;
    logic        last;
    logic        capture;
    logic [31:0] trimmed;
    logic [31:0] ext;

    dmem_range_check #(
        .MEM_BYTES(MEM_BYTES)
    ) u_chk (
        .addr    (addr_i),
        .num     (num_i),
        .overflow(ovf),
        .misalign(mis)
    );

    assign accept = (state_q == ST_IDLE) && req_i;
    assign last   = (beat_q == last_beat(num_q));

    // A read issued on beat k returns one cycle later, so bytes arrive
    // on beats 1..N-1 and in DRAIN.
    assign capture = ((state_q == ST_XFER) && (beat_q != 2'd0) && !we_q)
                  || (state_q == ST_DRAIN);

    // Left-justify store data so beats always take the top byte.
    always_comb begin
        unique case (num_i)
            SZ_WORD: trimmed = wdata_i;
            SZ_HALF: trimmed = {wdata_i[15:0], 16'h0};
            SZ_BYTE: trimmed = {wdata_i[7:0], 24'h0};
            default: trimmed = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (ovf || mis || (num_i == SZ_NONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (last) begin
                    state_d = we_q ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = (ovf_q || mis_q) ? ST_HALT : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            num_q   <= SZ_NONE;
            addr_q  <= '0;
            sdata_q <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                uns_q   <= unsigned_i;
                num_q   <= num_i;
                addr_q  <= addr_i[ADDR_W-1:0];
                sdata_q <= trimmed;
                acc_q   <= '0;
                beat_q  <= '0;
                ovf_q   <= ovf;
                mis_q   <= mis;
            end
            if (state_q == ST_XFER) begin
                beat_q  <= beat_q + 2'd1;
                sdata_q <= {sdata_q[23:0], 8'h0};
            end
            if (capture) begin
                acc_q <= {acc_q[23:0], mem_rdata_i};
            end
        end
    end

    always_comb begin
        unique case (num_q)
            SZ_HALF: ext = uns_q ? {16'h0, acc_q[15:0]}
                                 : {{16{acc_q[15]}}, acc_q[15:0]};
            SZ_BYTE: ext = uns_q ? {24'h0, acc_q[7:0]}
                                 : {{24{acc_q[7]}}, acc_q[7:0]};
            default: ext = acc_q;
        endcase
    end

    always_comb begin
        rdata_o                 = 32'h0;
        done_o                  = 1'b0;
        busy_o                  = 1'b0;
        error_addressOverflow_o = 1'b0;
        error_dataMisalign_o    = 1'b0;
        halt_o                  = 1'b0;
        mem_addr_o              = '0;
        mem_we_o                = 1'b0;
        mem_re_o                = 1'b0;
        mem_wdata_o             = 8'h0;
        unique case (state_q)
            ST_XFER: begin
                busy_o      = 1'b1;
                mem_addr_o  = addr_q + ADDR_W'(beat_q);
                mem_we_o    = we_q;
                mem_re_o    = !we_q;
                mem_wdata_o = we_q ? sdata_q[31:24] : 8'h0;
            end
            ST_DRAIN: busy_o = 1'b1;
            ST_DONE: begin
                busy_o                  = 1'b1;
                done_o                  = 1'b1;
                rdata_o                 = ext;
                error_addressOverflow_o = ovf_q;
                error_dataMisalign_o    = mis_q;
            end
            ST_HALT: halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl
// with a byte memory model and directed vectors.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  num_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        busy_o;
    logic        ovf_o;
    logic        mis_o;
    logic        halt_o;
    logic [9:0]  mem_addr_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata = 8'h0;

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .req_i                  (req_i),
        .we_i                   (we_i),
        .num_i                  (num_i),
        .unsigned_i             (unsigned_i),
        .addr_i                 (addr_i),
        .wdata_i                (wdata_i),
        .rdata_o                (rdata_o),
        .done_o                 (done_o),
        .busy_o                 (busy_o),
        .error_addressOverflow_o(ovf_o),
        .error_dataMisalign_o   (mis_o),
        .halt_o                 (halt_o),
        .mem_addr_o             (mem_addr_o),
        .mem_we_o               (mem_we_o),
        .mem_re_o               (mem_re_o),
        .mem_wdata_o            (mem_wdata_o),
        .mem_rdata_i            (mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [7:0]   mem [1024];
    logic       pl_en = 1'b0;
    logic [9:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_re_o) mem_rdata <= mem[mem_addr_o];
    end

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        ovf;
        logic        mis;
    } done_t;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic [7:0] data;
    } beat_t;

    done_t dq[$];
    beat_t wq[$];
    beat_t rq[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event at cycle %0d expected none",
                 name, cyc);
    endtask

    done_t md;
    beat_t mb;

    always @(negedge clk) begin
        if (done_o) begin
            if (dq.size() == 0) unexpected("extra_done");
            else begin
                md = dq.pop_front();
                check("done_cycle", cyc, md.cyc);
                check("rdata", rdata_o, md.rdata);
                check("overflow", {31'b0, ovf_o}, {31'b0, md.ovf});
                check("misalign", {31'b0, mis_o}, {31'b0, md.mis});
            end
        end
        if (mem_we_o) begin
            if (wq.size() == 0) unexpected("extra_write");
            else begin
                mb = wq.pop_front();
                check("wr_cycle", cyc, mb.cyc);
                check("wr_addr", {22'b0, mem_addr_o}, {22'b0, mb.addr});
                check("wr_data", {24'b0, mem_wdata_o}, {24'b0, mb.data});
            end
        end
        if (mem_re_o) begin
            if (rq.size() == 0) unexpected("extra_read");
            else begin
                mb = rq.pop_front();
                check("rd_cycle", cyc, mb.cyc);
                check("rd_addr", {22'b0, mem_addr_o}, {22'b0, mb.addr});
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // cut < 0: full access; cut >= 0: only cut beats expected (reset abort).
    task automatic issue(input logic we, input logic [1:0] num,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] exp_rd,
                         input logic ovf, input logic mis,
                         input int cut, input bit halted);
        int T;
        int n;
        int nb;
        int lat;
        bit legal;
        beat_t b;
        done_t d;
        T     = cyc;
        n     = (num == 2'b11) ? 4 : (num == 2'b10) ? 2 : 1;
        legal = !ovf && !mis && (num != 2'b00);
        lat   = !legal ? 1 : we ? n + 1 : n + 2;
        nb    = (cut < 0) ? n : cut;
        we_i       = we;
        num_i      = num;
        unsigned_i = uns;
        addr_i     = addr;
        wdata_i    = wdata;
        req_i      = 1'b1;
        if (!halted) begin
            if (cut < 0) begin
                d.cyc   = T + lat;
                d.rdata = exp_rd;
                d.ovf   = ovf;
                d.mis   = mis;
                dq.push_back(d);
            end
            if (legal) begin
                for (int j = 0; j < nb; j++) begin
                    b.cyc  = T + 1 + j;
                    b.addr = addr[9:0] + 10'(j);
                    if (num == 2'b11) b.data = wdata[31 - 8 * j -: 8];
                    else if (num == 2'b10) b.data = wdata[15 - 8 * j -: 8];
                    else b.data = wdata[7:0];
                    if (we) wq.push_back(b);
                    else rq.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
        req_i = 1'b0;
        if (!halted) check("busy_after_accept", {31'b0, busy_o}, 32'd1);
        if (halted) begin
            repeat (6) @(posedge clk);
            #1;
        end else if (cut < 0) begin
            repeat (lat) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_halt", {31'b0, halt_o}, 32'd0);
        check("rst_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_re", {31'b0, mem_re_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        @(posedge clk);
        #1;
        poke(10'h010, 8'hF6);
        poke(10'h011, 8'h01);
        poke(10'h020, 8'h80);
        poke(10'h021, 8'h01);
        poke(10'h022, 8'h02);
        poke(10'h023, 8'h03);
        poke(10'd1020, 8'h11);
        poke(10'd1021, 8'h22);
        poke(10'd1022, 8'h33);
        poke(10'd1023, 8'h85);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 2'b11, 0, 32'd8, 32'h12345678, 32'h0, 0, 0, -1, 0);
        check("mem11", {24'b0, mem[11]}, 32'h78);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hFFFFF601, 0, 0, -1, 0);
        issue(0, 2'b10, 1, 32'h10, 32'h0, 32'h0000F601, 0, 0, -1, 0);
        issue(0, 2'b11, 0, 32'h20, 32'h0, 32'h80010203, 0, 0, -1, 0);
        issue(0, 2'b11, 0, 32'd1020, 32'h0, 32'h11223385, 0, 0, -1, 0);
        issue(0, 2'b01, 0, 32'd1023, 32'h0, 32'hFFFFFF85, 0, 0, -1, 0);
        issue(0, 2'b01, 1, 32'd1023, 32'h0, 32'h00000085, 0, 0, -1, 0);
        issue(1, 2'b10, 0, 32'h40, 32'hABCD1234, 32'h0, 0, 0, -1, 0);
        issue(1, 2'b01, 0, 32'h45, 32'h99887766, 32'h0, 0, 0, -1, 0);
        check("mem45", {24'b0, mem[10'h45]}, 32'h66);
        issue(0, 2'b00, 0, 32'h30, 32'h0, 32'h0, 0, 0, -1, 0);
        check("none_halt", {31'b0, halt_o}, 32'd0);

        issue(0, 2'b11, 0, 32'd1022, 32'h0, 32'h0, 1, 1, -1, 0);
        check("err_halt", {31'b0, halt_o}, 32'd1);
        check("err_busy", {31'b0, busy_o}, 32'd0);
        issue(0, 2'b01, 0, 32'h10, 32'h0, 32'h0, 0, 0, -1, 1);
        check("still_halt", {31'b0, halt_o}, 32'd1);
        do_reset();
        check("halt_cleared", {31'b0, halt_o}, 32'd0);

        issue(0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 0, -1, 0);
        check("wrap_halt", {31'b0, halt_o}, 32'd1);
        do_reset();
        issue(1, 2'b11, 0, 32'd2, 32'h01020304, 32'h0, 0, 1, -1, 0);
        do_reset();

        issue(1, 2'b11, 0, 32'h60, 32'hAABBCCDD, 32'h0, 0, 0, 2, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_we", {31'b0, mem_we_o}, 32'd0);
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mem61", {24'b0, mem[10'h61]}, 32'hBB);
        check("abort_mem62", {24'b0, mem[10'h62]}, 32'h00);
        issue(0, 2'b11, 0, 32'h60, 32'h0, 32'hAABB0000, 0, 0, -1, 0);

        repeat (4) @(posedge clk);
        #1;
        check("pending_done", dq.size(), 32'd0);
        check("pending_wr", wq.size(), 32'd0);
        check("pending_rd", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle sequencer between the CPU load/store stage and a byte-wide, synchronous-read data memory of MEM_BYTES bytes.
- Accepts one word, half or byte request at a time and range/alignment-checks it before any memory cycle.
- Splits legal requests into big-endian byte beats and assembles load data with sign or zero extension.
- Reports overflow and misalignment errors with completion, then latches a sticky halt that blocks further requests until reset.

Parameters:
MEM_BYTES  1024  data memory size in bytes; legal byte addresses are 0..MEM_BYTES-1
ADDR_W     10    memory-side address width, equal to clog2(MEM_BYTES)

Ports:
clk_i                    in   1       clock, rising edge
rst_i                    in   1       asynchronous, active-low reset
req_i                    in   1       access request; sampled only in IDLE
we_i                     in   1       1 = store, 0 = load
num_i                    in   2       access size: 11 word, 10 half, 01 byte, 00 none
unsigned_i               in   1       load extension: 1 = zero-extend, 0 = sign-extend
addr_i                   in   32      byte address
wdata_i                  in   32      store data; half uses [15:0], byte uses [7:0]
rdata_o                  out  32      load result; valid only while done_o = 1
done_o                   out  1       one-cycle completion pulse
busy_o                   out  1       1 whenever state is not IDLE or HALT
error_addressOverflow_o  out  1       valid with done_o
error_dataMisalign_o     out  1       valid with done_o
halt_o                   out  1       sticky error halt
mem_addr_o               out  ADDR_W  memory byte address
mem_we_o                 out  1       byte write strobe
mem_re_o                 out  1       byte read strobe; data is returned on mem_rdata_i in the next cycle
mem_wdata_o              out  8       write byte
mem_rdata_i              in   8       read byte

Behaviour:
- Reset (asynchronous, rst_i = 0):
  - State goes to IDLE immediately; beat counter and accumulator are cleared.
  - Every output is 0, including halt_o, mem_we_o and mem_re_o; an in-flight burst is abandoned at once.
- States: IDLE, XFER, DRAIN, DONE, HALT.
- IDLE, with req_i = 1 and halt_o = 0 (cycle T):
  - Capture we_i, num_i, unsigned_i, addr_i, wdata_i.
  - Compute N = 4, 2 or 1 for num_i = 11, 10, 01.
  - Overflow = (addr_i + N - 1) >= MEM_BYTES, evaluated at 33-bit width so no wrap-around.
  - Misalign = (word and addr_i[1:0] != 0) or (half and addr_i[0] != 0).
  - Both errors may be flagged together.
  - If any error: go to DONE carrying the flags; no memory strobe is ever issued.
  - If num_i = 00: go to DONE with no flags and rdata_o = 0.
  - Otherwise: go to XFER with beat k = 0.
- XFER:
  - Beat k occupies cycle T+1+k, with mem_addr_o = addr[ADDR_W-1:0] + k.
  - Store: mem_we_o = 1; mem_wdata_o = byte k of the size-trimmed data, most-significant byte first (word: wdata[31:24] at k = 0).
  - Load: mem_re_o = 1.
  - After beat N-1: a store goes to DONE; a load goes to DRAIN.
- DRAIN: captures the last read byte; no strobes.
- Load assembly: each returned byte shifts into the accumulator from the LSB side, so the byte at the lowest address ends up most significant.
- DONE (one cycle):
  - done_o = 1; rdata_o = assembled value extended per unsigned_i (half extends from bit 15, byte from bit 7); error flags shown.
  - Next state is HALT if any error flag is set, else IDLE.
  - req_i is ignored in DONE; the requester drops or replaces its request during the done_o cycle.
- Outside DONE, rdata_o and both error outputs are 0.
- HALT:
  - halt_o = 1, busy_o = 0.
  - Requests are ignored and no done_o is produced; only reset exits.
- Latency:
  - Store completes at T+N+1.
  - Load completes at T+N+2.
  - Error or num = 00 completes at T+1.
- Throughput: the earliest next accept is the cycle after DONE.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_WORD = 2'b11, SZ_HALF = 2'b10, SZ_BYTE = 2'b01, SZ_NONE = 2'b00;
  - FSM state enumeration;
  - default MEM_BYTES.
- One sub-module, dmem_range_check: purely combinational; inputs addr and num, outputs overflow and misalign. It is reused wherever the same check is needed.
- The FSM, beat counter and accumulator stay in dmem_access_ctrl.

Test Plan:
- Word store 0x12345678 to addr 8 → writes 8:0x12, 9:0x34, 10:0x56, 11:0x78 in T+1..T+4; done_o at T+5; no error flags.
- Memory 0x10 = 0xF6, 0x11 = 0x01; half load from 0x10 signed → rdata_o = 0xFFFFF601 at T+4. Repeat with unsigned_i = 1 → rdata_o = 0x0000F601.
- Word load at 1022 → done_o at T+1 with overflow = 1 and misalign = 1; no mem strobes; halt_o = 1 from T+2. A later valid request produces no done_o and no strobes.
- Byte load at 1023 → legal, done_o at T+3. Half access at 0xFFFFFFFE → overflow = 1, misalign = 0; no wrap to address 0.
- num_i = 00 request → done_o at T+1, no flags, rdata_o = 0, no strobes, halt_o stays 0.
- Word store, rst_i pulled low after 2 beats → mem_we_o drops asynchronously; only the first 2 bytes are written; after reset release a new request completes normally.
